// File: rtl/accel_pkg.sv
// Shared accelerator types: element and tile formats plus the tile accumulator FSM states.
// Also used by the ReLU and pooling stages.
package accel_pkg;

  localparam int TILE_SIZE = 8;
  localparam int DATA_W    = 32;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [TILE_SIZE-1:0][TILE_SIZE-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

endpackage : accel_pkg

// File: rtl/tile_accumulator_if.sv
// Valid/ready tile bus between the MAC array (input side) and the ReLU stage (output side).
// The accumulator connects through the slave modport; the surrounding logic uses master.
interface tile_accumulator_if #(
  parameter int SIZE   = 8,
  parameter int DATA_W = 32
);

  logic                                  in_valid;
  logic                                  in_ready;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] in_tile;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] out_tile;
  logic                                  out_ovf;

  modport slave (
    input  in_valid, in_tile, out_ready,
    output in_ready, out_valid, out_tile, out_ovf
  );

  modport master (
    output in_valid, in_tile, out_ready,
    input  in_ready, out_valid, out_tile, out_ovf
  );

endinterface : tile_accumulator_if

// File: rtl/tile_accumulator_cell.sv
// One accumulator element: signed register with a load/add select and wrap-around
// overflow detection on the add path.
module acc_cell #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_load,
  input  logic                     i_add,
  input  logic signed [DATA_W-1:0] i_data,
  output logic signed [DATA_W-1:0] o_acc,
  output logic                     o_ovf
);

  logic signed [DATA_W-1:0] r_acc;
  logic signed [DATA_W-1:0] w_sum;

  assign w_sum = r_acc + i_data;
  // Overflow: operands share a sign but the wrapped sum does not.
  assign o_ovf = (r_acc[DATA_W-1] == i_data[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
  assign o_acc = r_acc;

  // NOTE: sequential state uses non-blocking assignments so every cell samples the
  // same pre-edge values; these are plain flops (not a RAM), so resetting them is cheap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= i_data;
    end else if (i_add) begin
      r_acc <= w_sum;
    end
  end

endmodule : acc_cell

// File: rtl/tile_accumulator.sv
// Sums cfg_k_tiles partial-sum tiles from the MAC array and presents the finished tile,
// held in the accumulator itself, to the ReLU stage until it is taken.
module tile_accumulator
  import accel_pkg::*;
#(
  parameter int SIZE   = 8,
  parameter int DATA_W = 32,
  parameter int KCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [KCNT_W-1:0] cfg_k_tiles,
  output logic              busy,
  tile_accumulator_if.slave bus
);

  acc_state_e                            r_state;
  logic [KCNT_W-1:0]                     r_cnt;
  logic [KCNT_W-1:0]                     r_k;
  logic                                  r_ovf;

  logic [KCNT_W-1:0]                     w_k_cfg;
  logic [KCNT_W-1:0]                     w_cnt_next;
  logic                                  w_in_fire;
  logic                                  w_load;
  logic                                  w_add;
  logic [SIZE*SIZE-1:0]                  w_cell_ovf;
  logic                                  w_ovf_any;
  logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] w_acc_tile;

  assign w_k_cfg    = (cfg_k_tiles == '0) ? KCNT_W'(1) : cfg_k_tiles;
  assign w_cnt_next = r_cnt + KCNT_W'(1);
  assign w_in_fire  = bus.in_valid && bus.in_ready;
  assign w_load     = w_in_fire && (r_state == IDLE);
  assign w_add      = w_in_fire && (r_state == ACCUM);
  assign w_ovf_any  = |w_cell_ovf;

  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      acc_cell #(
        .DATA_W (DATA_W)
      ) u_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_add  (w_add),
        .i_data (bus.in_tile[gi][gj]),
        .o_acc  (w_acc_tile[gi][gj]),
        .o_ovf  (w_cell_ovf[gi*SIZE+gj])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_k     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_cnt   <= KCNT_W'(1);
            r_k     <= w_k_cfg;
            r_ovf   <= 1'b0;
            r_state <= (w_k_cfg == KCNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (w_add) begin
            r_cnt <= w_cnt_next;
            r_ovf <= r_ovf | w_ovf_any;
            if (w_cnt_next == r_k) begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          // Accumulator is left as-is; the next IDLE load overwrites it.
          if (bus.out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state != HOLD);
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_tile  = w_acc_tile;
  assign bus.out_ovf   = r_ovf;
  assign busy          = (r_state != IDLE);

endmodule : tile_accumulator

// File: tb/tb_tile_accumulator.sv
// Directed self-checking bench for tile_accumulator: reset, pass-through, multi-tile
// accumulation, backpressure, overflow wrap and asynchronous mid-tile reset.
module tb_tile_accumulator;
  import accel_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] cfg_k_tiles;
  logic       busy;
  int         n_tests;
  int         n_fail;

  tile_accumulator_if #(.SIZE(TILE_SIZE), .DATA_W(DATA_W)) bus ();

  tile_accumulator #(
    .SIZE   (TILE_SIZE),
    .DATA_W (DATA_W),
    .KCNT_W (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_k_tiles (cfg_k_tiles),
    .busy        (busy),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tile(input string tag, input tile_t exp);
    tile_t obs;
    int    bi;
    int    bj;
    obs = bus.out_tile;
    bi  = 0;
    bj  = 0;
    for (int i = TILE_SIZE - 1; i >= 0; i--)
      for (int j = TILE_SIZE - 1; j >= 0; j--)
        if (obs[i][j] !== exp[i][j]) begin
          bi = i;
          bj = j;
        end
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: element[%0d][%0d] observed=%0h expected=%0h",
             tag, bi, bj, obs[bi][bj], exp[bi][bj]);
    end
  endtask

  function automatic tile_t fill(input int v);
    tile_t t;
    for (int i = 0; i < TILE_SIZE; i++)
      for (int j = 0; j < TILE_SIZE; j++)
        t[i][j] = v;
    return t;
  endfunction

  // Waits (bounded) for in_ready, then offers one tile for exactly one clock edge.
  task automatic send(input tile_t t, input logic [7:0] k);
    int waited;
    waited = 0;
    while (!bus.in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("send_in_ready", bus.in_ready, 1);
    bus.in_tile    = t;
    cfg_k_tiles    = k;
    bus.in_valid   = 1'b1;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_tile    = '0;
  endtask

  tile_t ramp;
  tile_t t_a;
  tile_t t_b;
  tile_t exp_t;

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    cfg_k_tiles   = 8'd1;
    bus.in_valid  = 1'b0;
    bus.in_tile   = '0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < TILE_SIZE; i++)
      for (int j = 0; j < TILE_SIZE; j++)
        ramp[i][j] = i * 8 + j;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_ovf", bus.out_ovf, 0);
    check_tile("rst_out_tile", fill(0));

    // k=1 pass-through, then cfg 0 treated as 1
    send(ramp, 8'd1);
    check("k1_out_valid", bus.out_valid, 1);
    check("k1_in_ready", bus.in_ready, 0);
    check("k1_busy", busy, 1);
    check("k1_ovf", bus.out_ovf, 0);
    check_tile("k1_tile", ramp);
    tick();
    check("k1_back_idle", bus.out_valid, 0);
    check("k1_idle_ready", bus.in_ready, 1);

    send(ramp, 8'd0);
    check("k0_out_valid", bus.out_valid, 1);
    check("k0_ovf", bus.out_ovf, 0);
    check_tile("k0_tile", ramp);
    tick();
    check("k0_back_idle", busy, 0);

    // k=4 with idle gaps; later cfg values of 1 must be ignored mid-tile
    send(fill(5), 8'd4);
    check("k4_after1_valid", bus.out_valid, 0);
    repeat (2) tick();
    send(fill(0), 8'd1);
    check("k4_after2_valid", bus.out_valid, 0);
    check("k4_after2_busy", busy, 1);
    repeat (2) tick();
    send(fill(-3), 8'd1);
    check("k4_after3_valid", bus.out_valid, 0);
    repeat (2) tick();
    bus.out_ready = 1'b0;
    send(fill(10), 8'd1);
    check("k4_out_valid", bus.out_valid, 1);
    check("k4_ovf", bus.out_ovf, 0);
    check_tile("k4_tile", fill(12));

    // Backpressure: junk offered while held must not be taken
    bus.in_tile  = fill(99);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      check_tile("bp_tile_stable", fill(12));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.in_tile  = '0;
    check("bp_release_valid", bus.out_valid, 0);
    check("bp_release_busy", busy, 0);
    send(fill(3), 8'd1);
    check("bp_fresh_valid", bus.out_valid, 1);
    check_tile("bp_fresh_tile", fill(3));
    tick();

    // Overflow wrap on element [0][0]
    t_a = fill(1);
    t_a[0][0] = 32'sh7FFF_FFFF;
    t_b = fill(2);
    t_b[0][0] = 32'sh0000_0001;
    exp_t = fill(3);
    exp_t[0][0] = 32'sh8000_0000;
    send(t_a, 8'd2);
    send(t_b, 8'd2);
    check("ovf_out_valid", bus.out_valid, 1);
    check("ovf_flag", bus.out_ovf, 1);
    check_tile("ovf_tile", exp_t);
    tick();
    send(fill(1), 8'd2);
    send(fill(1), 8'd2);
    check("ovf_clear_valid", bus.out_valid, 1);
    check("ovf_clear_flag", bus.out_ovf, 0);
    check_tile("ovf_clear_tile", fill(2));
    tick();

    // Asynchronous reset in the middle of a k=3 tile
    send(fill(9), 8'd3);
    send(fill(9), 8'd3);
    check("mid_busy", busy, 1);
    check("mid_out_valid", bus.out_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_ovf", bus.out_ovf, 0);
    check_tile("arst_tile", fill(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(fill(7), 8'd1);
    check("post_rst_valid", bus.out_valid, 1);
    check_tile("post_rst_tile", fill(7));
    tick();
    check("post_rst_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule : tb_tile_accumulator

// File: doc/tile_accumulator.md
Name: tile_accumulator

Overview:
Accumulates SIZE x SIZE signed partial-sum tiles from the systolic MAC array over a configurable number of K-tiles and emits one finished tile per output. Sits directly upstream of the ReLU activation array; out_tile drives its weights_in bus unchanged. Valid/ready handshakes run on both sides, and a single holding register provides backpressure to the MAC array.

Parameters:
SIZE, 8, tile edge length (tile is SIZE x SIZE elements)
DATA_W, 32, element width, signed two's complement
KCNT_W, 8, width of K-tile count and internal counter

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
cfg_k_tiles  in  KCNT_W  number of partial tiles to sum; sampled on first accepted tile; 0 treated as 1
in_valid  in  1  in_tile holds a valid partial-sum tile
in_ready  out  1  block accepts in_tile this cycle
in_tile  in  [SIZE][SIZE] x DATA_W  partial-sum tile, signed
out_valid  out  1  out_tile holds a completed sum
out_ready  in  1  downstream (ReLU / output buffer) accepts out_tile
out_tile  out  [SIZE][SIZE] x DATA_W  accumulated tile, signed
out_ovf  out  1  sticky: some element overflowed during this tile; qualified by out_valid
busy  out  1  high in ACCUM or HOLD

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE, acc=0, cnt=0, k_reg=0, ovf=0; in_ready=1 after reset, out_valid=0, out_tile=0, out_ovf=0, busy=0. Mid-operation reset discards the partial tile; no output is produced for it.
- Transfer occurs when valid && ready in the same cycle. Data is never dropped or duplicated.
- State IDLE: in_ready=1, out_valid=0. On accept: acc<=in_tile, cnt<=1, k_reg<=max(cfg_k_tiles,1), ovf<=0. If k_reg==1, go to HOLD; otherwise go to ACCUM.
- State ACCUM: in_ready=1. On accept: acc[i][j]<=acc[i][j]+in_tile[i][j] for every element in parallel, cnt<=cnt+1, ovf<=ovf | any element overflow. If cnt+1==k_reg, go to HOLD. Without in_valid the state holds with no change.
- State HOLD: in_ready=0, out_valid=1, out_tile=acc, out_ovf=ovf. out_tile and out_ovf stay stable while out_valid && !out_ready. On out_ready, go to IDLE; acc is not cleared, because the next load overwrites it.
- Latency: out_valid rises the cycle after the last partial tile is accepted. Throughput is k_reg+1 cycles per output tile, with one bubble during the HOLD handoff.
- Arithmetic: signed DATA_W add with wrap-around (no saturation). Overflow of an element is a carry into the sign with matching operand signs and a result sign that differs.
- cfg_k_tiles changes are ignored after the first accept of a tile and take effect on the next tile.
- in_tile is ignored whenever in_ready=0, including X values.
- out_valid never depends combinationally on out_ready. in_ready depends only on state.

Decomposition:
- Shared package accel_pkg holds:
  - localparams TILE_SIZE=8 and DATA_W=32
  - typedef elem_t (logic signed [DATA_W-1:0])
  - typedef tile_t (elem_t [TILE_SIZE-1:0][TILE_SIZE-1:0]), also reused by the ReLU and pooling stages
  - enum acc_state_e {IDLE, ACCUM, HOLD}
- Sub-module acc_cell: one element's register, adder and overflow detect, with a load/add select. It is instantiated SIZE*SIZE times via generate. The FSM and counter stay in the top module.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> in_ready=1, out_valid=0, out_tile all 0, busy=0.
- k=1 passthrough: cfg_k_tiles=1, one tile with element[i][j]=i*8+j -> out_valid on the next cycle, out_tile identical, out_ovf=0. Repeat with cfg_k_tiles=0 -> same result.
- k=4 accumulate with gaps: four tiles of all 5, 0, -3, 10, with 2 idle cycles between tiles -> a single output with every element 12, asserted exactly one cycle after the 4th accept.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_tile stable, in_ready=0, and in_valid asserted with a junk tile is not accepted. Then out_ready=1 -> returns to IDLE, and the next tile loads fresh with no stale sum.
- Overflow wrap: k=2, element[0][0]=0x7FFFFFFF then +1 -> out_tile[0][0]=0x80000000, out_ovf=1. The next tile with small values -> out_ovf=0.
- Reset mid-tile: k=3, two tiles accepted, then rst_n pulsed low asynchronously between clock edges -> outputs go to their reset values immediately. A new k=1 tile of all 7 -> output is all 7.
